// File: rtl/pixel_row_scan.sv
// Scans a playfield bottom-up through a frame-buffer read port looking for a completely filled row.
// Optional FULL_COUNT_EN: keep scanning past full rows and report how many were found on full_count.
module pixel_row_scan #(
   parameter int COLS = 10,
   parameter int ROWS = 20,
   parameter int CELL = 4,
   parameter int X0   = 0,
   parameter int Y0   = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   output logic [6:0] rd_x,
   output logic [6:0] rd_y,
   output logic       rd_en,
   input  logic [2:0] rd_colour,
   output logic       busy,
   output logic       done,
   output logic       full_found,
   output logic [4:0] full_row,
`ifdef FULL_COUNT_EN
   output logic [6:0] full_y,
   output logic [4:0] full_count
`else
   output logic [6:0] full_y
`endif
);

   typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} scanState_t;

   scanState_t r_state;
   scanState_t w_nextState;
   logic [4:0] r_row;
   logic [4:0] r_col;
   logic [4:0] w_nextRow;
   logic [4:0] w_nextCol;
   logic       w_setFull;
   logic       w_clearFull;
   logic [6:0] r_rdX;
   logic [6:0] r_rdY;
   logic       r_fullFound;
   logic [4:0] r_fullRow;
   logic [6:0] r_fullY;
`ifdef FULL_COUNT_EN
   logic [4:0] r_fullCount;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextRow   = r_row;
      w_nextCol   = r_col;
      w_setFull   = 1'b0;
      w_clearFull = 1'b0;
      case (r_state)
         IDLE: begin
            if (go) begin
               w_nextRow   = 5'(ROWS - 1);
               w_nextCol   = 5'd0;
               w_clearFull = 1'b1;
               w_nextState = READ;
            end
         end
         READ: w_nextState = WAIT;
         WAIT: begin
            if (rd_colour != 3'b000) begin
               if (r_col != 5'(COLS - 1)) begin
                  w_nextCol   = r_col + 5'd1;
                  w_nextState = READ;
               end else begin
                  w_setFull = 1'b1;
`ifdef FULL_COUNT_EN
                  if (r_row != 5'd0) begin
                     w_nextRow   = r_row - 5'd1;
                     w_nextCol   = 5'd0;
                     w_nextState = READ;
                  end else begin
                     w_nextState = DONE;
                  end
`else
                  w_nextState = DONE;
`endif
               end
            end else if (r_row != 5'd0) begin
               w_nextRow   = r_row - 5'd1;
               w_nextCol   = 5'd0;
               w_nextState = READ;
            end else begin
               w_nextState = DONE;
            end
         end
         DONE: w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Addresses are computed on entry to READ so they are stable for the whole read cycle and held afterwards.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_row       <= 5'd0;
         r_col       <= 5'd0;
         r_rdX       <= 7'd0;
         r_rdY       <= 7'd0;
         r_fullFound <= 1'b0;
         r_fullRow   <= 5'd0;
         r_fullY     <= 7'd0;
`ifdef FULL_COUNT_EN
         r_fullCount <= 5'd0;
`endif
      end else begin
         r_row <= w_nextRow;
         r_col <= w_nextCol;
         if (w_nextState == READ) begin
            r_rdX <= 7'(X0) + 7'(w_nextCol) * 7'(CELL);
            r_rdY <= 7'(Y0) + 7'(w_nextRow) * 7'(CELL);
         end
         if (w_clearFull) begin
            r_fullFound <= 1'b0;
            r_fullRow   <= 5'd0;
            r_fullY     <= 7'd0;
`ifdef FULL_COUNT_EN
            r_fullCount <= 5'd0;
`endif
         end else if (w_setFull) begin
            // Scanning runs bottom-up, so the first full row seen is the bottom-most one.
            if (!r_fullFound) begin
               r_fullFound <= 1'b1;
               r_fullRow   <= r_row;
               r_fullY     <= 7'(Y0) + 7'(r_row) * 7'(CELL);
            end
`ifdef FULL_COUNT_EN
            r_fullCount <= r_fullCount + 5'd1;
`endif
         end
      end
   end

   assign rd_x       = r_rdX;
   assign rd_y       = r_rdY;
   assign rd_en      = (r_state == READ);
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == DONE);
   assign full_found = r_fullFound;
   assign full_row   = r_fullRow;
   assign full_y     = r_fullY;
`ifdef FULL_COUNT_EN
   assign full_count = r_fullCount;
`endif

endmodule

// File: tb/tb_pixel_row_scan.sv
// Directed bench for pixel_row_scan with a cell-granular frame-buffer model behind the read port.
// Expected done cycles and full-row results are hand-computed; FULL_COUNT_EN selects the counting build.
module tb_pixel_row_scan;

   logic       clock;
   logic       reset;
   logic       go;
   logic [6:0] rd_x;
   logic [6:0] rd_y;
   logic       rd_en;
   logic [2:0] rd_colour;
   logic       busy;
   logic       done;
   logic       full_found;
   logic [4:0] full_row;
   logic [6:0] full_y;
`ifdef FULL_COUNT_EN
   logic [4:0] full_count;
   localparam bit CONTINUE_ON_FULL = 1'b1;
`else
   localparam bit CONTINUE_ON_FULL = 1'b0;
`endif

   logic [2:0] fb [0:19][0:9];
   int         expQ[$];
   int         assertCount = 0;
   int         failCount = 0;

   pixel_row_scan #(.COLS(10), .ROWS(20), .CELL(4), .X0(0), .Y0(0)) dut (
      .clock(clock),
      .reset(reset),
      .go(go),
      .rd_x(rd_x),
      .rd_y(rd_y),
      .rd_en(rd_en),
      .rd_colour(rd_colour),
      .busy(busy),
      .done(done),
      .full_found(full_found),
      .full_row(full_row),
`ifdef FULL_COUNT_EN
      .full_y(full_y),
      .full_count(full_count)
`else
      .full_y(full_y)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Frame-buffer read port: one cycle of latency from rd_en to rd_colour.
   always @(posedge clock or posedge reset) begin
      if (reset) rd_colour <= 3'b000;
      else if (rd_en) rd_colour <= fb[rd_y[6:2]][rd_x[6:2]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic clearFb();
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 10; c++)
            fb[r][c] = 3'b000;
   endtask

   task automatic fillRow(input int row, input logic [2:0] colour);
      for (int c = 0; c < 10; c++) fb[row][c] = colour;
   endtask

   // Reference order of cell reads for the current buffer contents, encoded row*32+col.
   task automatic buildExpected();
      int  row;
      bit  rowFull;
      bit  stop;
      expQ.delete();
      row  = 19;
      stop = 1'b0;
      while (!stop) begin
         rowFull = 1'b1;
         for (int c = 0; c < 10; c++) begin
            expQ.push_back(row * 32 + c);
            if (fb[row][c] == 3'b000) begin
               rowFull = 1'b0;
               break;
            end
         end
         if (rowFull && !CONTINUE_ON_FULL) stop = 1'b1;
         else if (row == 0) stop = 1'b1;
         else row--;
      end
   endtask

   task automatic applyStimulus(input string tag, input int expDone, input bit expFound,
                                input int expRow, input int expY, input int expCount,
                                input int goBusyCycle, input bit goAtDone);
      int cycle;
      int doneCycle;
      int exp;
      buildExpected();
      @(negedge clock);
      go = 1'b1;
      cycle = 0;
      doneCycle = -1;
      while (doneCycle < 0 && cycle < 300) begin
         @(negedge clock);
         cycle++;
         go = (cycle == goBusyCycle);
         if (cycle == 1) checkOutput({tag, " busy"}, 32'(busy), 32'd1);
         if (rd_en) begin
            if (expQ.size() == 0) begin
               checkOutput({tag, " unexpected read"}, 32'd1, 32'd0);
            end else begin
               exp = expQ.pop_front();
               checkOutput({tag, " rd_x"}, 32'(rd_x), 32'((exp % 32) * 4));
               checkOutput({tag, " rd_y"}, 32'(rd_y), 32'((exp / 32) * 4));
            end
         end
         if (done) doneCycle = cycle;
      end
      checkOutput({tag, " done cycle"}, 32'(doneCycle), 32'(expDone));
      checkOutput({tag, " reads left"}, 32'(expQ.size()), 32'd0);
      checkOutput({tag, " full_found"}, 32'(full_found), 32'(expFound));
      checkOutput({tag, " full_row"}, 32'(full_row), 32'(expRow));
      checkOutput({tag, " full_y"}, 32'(full_y), 32'(expY));
`ifdef FULL_COUNT_EN
      checkOutput({tag, " full_count"}, 32'(full_count), 32'(expCount));
`else
      if (expCount < 0) checkOutput({tag, " count arg"}, 32'(expCount), 32'd0);
`endif
      if (goAtDone) go = 1'b1;
      @(negedge clock);
      go = 1'b0;
      checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
      checkOutput({tag, " done pulse width"}, 32'(done), 32'd0);
      @(negedge clock);
      checkOutput({tag, " stays idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      bit doneSeen;
      bit busySeen;
      reset = 1'b1;
      go    = 1'b0;
      clearFb();
      repeat (2) @(negedge clock);
      checkOutput("reset rd_x", 32'(rd_x), 32'd0);
      checkOutput("reset rd_y", 32'(rd_y), 32'd0);
      checkOutput("reset rd_en", 32'(rd_en), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset full_found", 32'(full_found), 32'd0);
      checkOutput("reset full_row", 32'(full_row), 32'd0);
      checkOutput("reset full_y", 32'(full_y), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      $display("[TB] all-black buffer, go while busy and go during DONE");
      applyStimulus("black", 41, 1'b0, 0, 0, 0, 5, 1'b1);

      $display("[TB] row 19 full");
      clearFb();
      fillRow(19, 3'b010);
`ifdef FULL_COUNT_EN
      applyStimulus("row19", 59, 1'b1, 19, 76, 1, 0, 1'b0);
`else
      applyStimulus("row19", 21, 1'b1, 19, 76, 0, 0, 1'b0);
`endif

      $display("[TB] row 19 hole at col 5, row 18 full");
      clearFb();
      fillRow(19, 3'b101);
      fb[19][5] = 3'b000;
      fillRow(18, 3'b111);
`ifdef FULL_COUNT_EN
      applyStimulus("row18", 69, 1'b1, 18, 72, 1, 0, 1'b0);
`else
      applyStimulus("row18", 33, 1'b1, 18, 72, 0, 0, 1'b0);
`endif

      $display("[TB] rows 19 and 17 full");
      clearFb();
      fillRow(19, 3'b001);
      fillRow(17, 3'b100);
`ifdef FULL_COUNT_EN
      applyStimulus("two full", 77, 1'b1, 19, 76, 2, 0, 1'b0);
`else
      applyStimulus("two full", 21, 1'b1, 19, 76, 0, 0, 1'b0);
`endif

      $display("[TB] reset in the middle of a scan");
      clearFb();
      @(negedge clock);
      go = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clock);
         go = (c == 3);
      end
      checkOutput("mid rd_en", 32'(rd_en), 32'd1);
      checkOutput("mid rd_y", 32'(rd_y), 32'd64);
      reset = 1'b1;
      #1;
      checkOutput("mid reset rd_y", 32'(rd_y), 32'd0);
      checkOutput("mid reset rd_en", 32'(rd_en), 32'd0);
      checkOutput("mid reset busy", 32'(busy), 32'd0);
      checkOutput("mid reset done", 32'(done), 32'd0);
      doneSeen = 1'b0;
      busySeen = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (done) doneSeen = 1'b1;
      end
      reset = 1'b0;
      repeat (30) begin
         @(negedge clock);
         if (done) doneSeen = 1'b1;
         if (busy) busySeen = 1'b1;
      end
      checkOutput("no done after reset", 32'(doneSeen), 32'd0);
      checkOutput("no restart after reset", 32'(busySeen), 32'd0);

      $display("[TB] scan after reset recovery");
      fillRow(19, 3'b011);
`ifdef FULL_COUNT_EN
      applyStimulus("recover", 59, 1'b1, 19, 76, 1, 0, 1'b0);
`else
      applyStimulus("recover", 21, 1'b1, 19, 76, 0, 0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
